// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame snapshot, hex mode,
// per-digit blank/dp and leading-zero suppression. Optional macro: GHOST_BLANK_EN.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 6,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned COM_ACTIVE_LOW = 1,
    parameter int unsigned BLANK_CYCLES   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic                          hex_mode,
    input  logic                          lz_en,
    output logic [7:0]                    seg_data,
    output logic [NUM_DIGITS-1:0]         com_sel,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] COM_OFF   = {NUM_DIGITS{COM_ACTIVE_LOW != 0}};
`ifdef GHOST_BLANK_EN
    localparam logic GHOST = 1'b1;
`else
    localparam logic GHOST = 1'b0;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] code, input logic hex);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            4'd10:   s = hex ? 7'h77 : 7'h00;
            4'd11:   s = hex ? 7'h7C : 7'h00;
            4'd12:   s = hex ? 7'h39 : 7'h00;
            4'd13:   s = hex ? 7'h5E : 7'h00;
            4'd14:   s = hex ? 7'h79 : 7'h00;
            default: s = hex ? 7'h71 : 7'h00;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic                  act_q, act_d;
    logic [DIG_W-1:0]      snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0] snap_blank_q, snap_blank_d;
    logic                  snap_hex_q, snap_hex_d;
    logic                  snap_lz_q, snap_lz_d;

    logic                  tick;
    logic                  frame;
    logic [IDX_W-1:0]      idx_nx;
    logic [DIG_W-1:0]      src_dig;
    logic [NUM_DIGITS-1:0] src_dp;
    logic [NUM_DIGITS-1:0] src_blank;
    logic                  src_hex;
    logic                  src_lz;
    logic [3:0]            code;
    logic                  upper_nz;
    logic                  dark;
    logic [7:0]            seg_dec;
    logic [NUM_DIGITS-1:0] onehot;

    // Slot sequencing, decode of the upcoming digit and output staging
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        seg_d        = seg_q;
        act_d        = act_q;
        snap_dig_d   = snap_dig_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        snap_hex_d   = snap_hex_q;
        snap_lz_d    = snap_lz_q;

        tick   = en && (cnt_q == CNT_LAST);
        idx_nx = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        frame  = (idx_nx == '0);

        // Slot 0 decodes the live inputs on the same edge the snapshot is taken
        src_dig   = frame ? digits_in : snap_dig_q;
        src_dp    = frame ? dp_in     : snap_dp_q;
        src_blank = frame ? blank_in  : snap_blank_q;
        src_hex   = frame ? hex_mode  : snap_hex_q;
        src_lz    = frame ? lz_en     : snap_lz_q;

        code     = src_dig[{idx_nx, 2'b00} +: 4];
        upper_nz = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if ((k >= int'(idx_nx)) && (src_dig[4*k +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
        dark    = src_blank[idx_nx] || (src_lz && (idx_nx != '0) && !upper_nz);
        seg_dec = dark ? 8'h00 : {src_dp[idx_nx], seg7(code, src_hex)};

        if (!en) begin
            seg_d = 8'h00;
            act_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = idx_nx;
            seg_d = seg_dec;
            act_d = 1'b1;
            if (frame) begin
                snap_dig_d   = digits_in;
                snap_dp_d    = dp_in;
                snap_blank_d = blank_in;
                snap_hex_d   = hex_mode;
                snap_lz_d    = lz_en;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        onehot = NUM_DIGITS'(1) << idx_d;
        com_d  = COM_OFF;
        if (act_d && !(GHOST && (cnt_d < CNT_BLANK))) begin
            com_d = (COM_ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= IDX_LAST;
            seg_q        <= 8'h00;
            com_q        <= COM_OFF;
            act_q        <= 1'b0;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            snap_hex_q   <= 1'b0;
            snap_lz_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            com_q        <= com_d;
            act_q        <= act_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            snap_hex_q   <= snap_hex_d;
            snap_lz_q    <= snap_lz_d;
        end
    end

    assign seg_data  = seg_q;
    assign com_sel   = com_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4 cycles per slot, active-low commons.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
`ifdef GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        hex_mode;
    logic        lz_en;
    logic [7:0]  seg_data;
    logic [3:0]  com_sel;
    logic [1:0]  digit_idx;

    seg_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .COM_ACTIVE_LOW(1), .BLANK_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .hex_mode(hex_mode), .lz_en(lz_en),
        .seg_data(seg_data), .com_sel(com_sel), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        hx;
        logic        lz;
        logic [7:0]  s0, s1, s2, s3;
    } vec_t;

    vec_t tbl[9];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    int   m_idx = ND - 1;
    bit   m_act = 1'b0;
    bit   m_new = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Timing model of slot position, advanced once per clock
    task automatic step();
        @(posedge clk);
        m_new = 1'b0;
        if (rst) begin
            m_cnt = 0; m_idx = ND - 1; m_act = 1'b0;
        end else if (en) begin
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
                m_act = 1'b1;
                m_new = 1'b1;
            end else begin
                m_cnt++;
            end
        end else begin
            m_act = 1'b0;
        end
        #1;
    endtask

    function automatic logic [3:0] exp_com();
        if (!m_act || (GHOST && m_cnt < 2)) return 4'hF;
        return ~(4'b0001 << m_idx);
    endfunction

    task automatic apply(input vec_t v);
        digits_in = v.d; dp_in = v.dp; blank_in = v.bl; hex_mode = v.hx; lz_en = v.lz;
    endtask

    task automatic run_to_frame();
        int guard = 0;
        do begin
            step();
            guard++;
        end while (!(m_new && m_idx == 0) && guard < 64);
    endtask

    // Walk one full frame from the start of slot 0, checking every cycle
    task automatic check_frame(input string tag, input vec_t v);
        logic [7:0] e[4];
        e[0] = v.s0; e[1] = v.s1; e[2] = v.s2; e[3] = v.s3;
        for (int j = 0; j < ND; j++) begin
            for (int c = 0; c < SD; c++) begin
                chk($sformatf("%s d%0d c%0d idx", tag, j, c), 16'(digit_idx), 16'(j));
                chk($sformatf("%s d%0d c%0d seg", tag, j, c), 16'(seg_data), 16'(e[j]));
                chk($sformatf("%s d%0d c%0d com", tag, j, c), 16'(com_sel), 16'(exp_com()));
                step();
            end
        end
    endtask

    initial begin
        logic [7:0] mid_exp[6];
        tbl[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h66, 8'h4F, 8'h5B, 8'h06};
        tbl[1] = '{16'h00A5, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h6D, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{16'h00A5, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h6D, 8'h77, 8'h00, 8'h00};
        tbl[3] = '{16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h3F, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'h3F, 8'h3F, 8'hBF, 8'h3F};
        tbl[5] = '{16'hFEDC, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h39, 8'h5E, 8'h79, 8'h71};
        tbl[6] = '{16'h89BF, 4'b1111, 4'b0010, 1'b0, 1'b0, 8'h80, 8'h00, 8'hEF, 8'hFF};
        tbl[7] = '{16'h0607, 4'b1000, 4'b0000, 1'b0, 1'b1, 8'h07, 8'h3F, 8'h7D, 8'h00};
        tbl[8] = '{16'h0012, 4'b0001, 4'b0001, 1'b0, 1'b1, 8'h00, 8'h06, 8'h00, 8'h00};

        // Reset state and first-tick latency
        rst = 1'b1; en = 1'b0;
        apply(tbl[0]);
        step(); step(); step();
        chk("reset seg", 16'(seg_data), 16'h00);
        chk("reset com", 16'(com_sel), 16'hF);
        chk("reset idx", 16'(digit_idx), 16'd3);
        rst = 1'b0; en = 1'b1;
        for (int i = 1; i < SD; i++) begin
            step();
            chk($sformatf("pre-tick c%0d idx", i), 16'(digit_idx), 16'd3);
            chk($sformatf("pre-tick c%0d com", i), 16'(com_sel), 16'hF);
            chk($sformatf("pre-tick c%0d seg", i), 16'(seg_data), 16'h00);
        end
        step();
        chk("first tick idx", 16'(digit_idx), 16'd0);
        check_frame("v0", tbl[0]);

        for (int i = 1; i < 9; i++) begin
            apply(tbl[i]);
            run_to_frame();
            check_frame($sformatf("v%0d", i), tbl[i]);
        end

        // Mid-frame input change stays invisible until the next frame
        apply(tbl[0]);
        run_to_frame();
        for (int c = 0; c < SD; c++) step();
        chk("mid idx1 seg", 16'(seg_data), 16'h4F);
        digits_in = 16'h5678;
        mid_exp[0] = 8'h5B; mid_exp[1] = 8'h06; mid_exp[2] = 8'h7F;
        mid_exp[3] = 8'h07; mid_exp[4] = 8'h7D; mid_exp[5] = 8'h6D;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < SD; c++) step();
            chk($sformatf("mid s%0d idx", s), 16'(digit_idx), 16'((s + 2) % ND));
            chk($sformatf("mid s%0d seg", s), 16'(seg_data), 16'(mid_exp[s]));
        end

        // Enable dropped mid-slot, then restored
        step(); step();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("en0 c%0d seg", c), 16'(seg_data), 16'h00);
            chk($sformatf("en0 c%0d com", c), 16'(com_sel), 16'hF);
            chk($sformatf("en0 c%0d idx", c), 16'(digit_idx), 16'd3);
        end
        en = 1'b1;
        step();
        chk("en1 c0 seg", 16'(seg_data), 16'h00);
        chk("en1 c0 com", 16'(com_sel), 16'hF);
        chk("en1 c0 idx", 16'(digit_idx), 16'd3);
        step();
        chk("en1 tick idx", 16'(digit_idx), 16'd0);
        chk("en1 tick seg", 16'(seg_data), 16'h7F);
        chk("en1 tick com", 16'(com_sel), 16'(GHOST ? 4'hF : 4'hE));

        // Reset mid-slot wins over enable
        step();
        rst = 1'b1;
        step();
        chk("rst mid idx", 16'(digit_idx), 16'd3);
        chk("rst mid com", 16'(com_sel), 16'hF);
        chk("rst mid seg", 16'(seg_data), 16'h00);
        rst = 1'b0;
        for (int c = 1; c < SD; c++) begin
            step();
            chk($sformatf("post-rst c%0d idx", c), 16'(digit_idx), 16'd3);
        end
        step();
        chk("post-rst tick idx", 16'(digit_idx), 16'd0);
        chk("post-rst tick seg", 16'(seg_data), 16'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
